// File: rtl/wordle_checker_if.sv
// Guess/result bus between the keyboard path, the Wordle scoring block and its consumers.
// Letters move on letter_valid && letter_ready; a result is taken on result_valid && result_ack.
interface wordle_checker_if;
    logic [24:0] answer;
    logic [4:0]  letter;
    logic        letter_valid;
    logic        letter_ready;
    logic [9:0]  result;
    logic        win;
    logic        result_valid;
    logic        result_ack;
    logic [1:0]  dbg_state;

    modport master (
        output answer,
        output letter,
        output letter_valid,
        output result_ack,
        input  letter_ready,
        input  result,
        input  win,
        input  result_valid,
        input  dbg_state
    );

    modport slave (
        input  answer,
        input  letter,
        input  letter_valid,
        input  result_ack,
        output letter_ready,
        output result,
        output win,
        output result_valid,
        output dbg_state
    );
endinterface

// File: rtl/wordle_checker.sv
// Scores a five-letter guess against the latched answer: one green pass, then a
// five-cycle yellow pass that consumes answer letters so duplicates are not over-credited.
module wordle_checker (
    input  logic             Clk,
    input  logic             reset,
    wordle_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [2:0]  cnt_q;
    logic [2:0]  idx_q;
    logic [4:0]  guess_q [5];
    logic [4:0]  ans_q   [5];
    logic [4:0]  green_q;
    logic [4:0]  avail_q;
    logic [9:0]  result_q;
    logic        win_q;

    logic        accept;
    logic [4:0]  green_w;
    logic [9:0]  result_grn;
    logic [4:0]  cur_letter;
    logic        found;
    logic [2:0]  hit_j;
    logic        grant;
    logic [9:0]  result_upd;
    logic [4:0]  avail_upd;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            COLLECT: begin
                if (bus.letter_valid) begin
                    accept = 1'b1;
                    if (cnt_q == 3'd4) begin
                        state_d = GREEN;
                    end
                end
            end
            GREEN: begin
                state_d = YELLOW;
            end
            YELLOW: begin
                if (idx_q == 3'd4) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.result_ack) begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Green pass: exact position matches
    // ------------------------------------------------------------------
    always_comb begin
        green_w    = '0;
        result_grn = '0;
        for (int k = 0; k < 5; k++) begin
            green_w[k]           = (guess_q[k] == ans_q[k]);
            result_grn[2*k +: 2] = green_w[k] ? 2'b10 : 2'b00;
        end
    end

    // ------------------------------------------------------------------
    // Yellow pass: lowest still-available answer letter equal to guess[idx]
    // ------------------------------------------------------------------
    always_comb begin
        cur_letter = guess_q[idx_q];
        found      = 1'b0;
        hit_j      = '0;
        for (int j = 0; j < 5; j++) begin
            if (!found && avail_q[j] && (ans_q[j] == cur_letter)) begin
                found = 1'b1;
                hit_j = 3'(j);
            end
        end
        grant = found && !green_q[idx_q];
    end

    always_comb begin
        result_upd = result_q;
        avail_upd  = avail_q;
        for (int k = 0; k < 5; k++) begin
            if (grant && (idx_q == 3'(k))) begin
                result_upd[2*k +: 2] = 2'b01;
            end
            if (grant && (hit_j == 3'(k))) begin
                avail_upd[k] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            green_q  <= '0;
            avail_q  <= '0;
            result_q <= '0;
            win_q    <= 1'b0;
            for (int k = 0; k < 5; k++) begin
                guess_q[k] <= '0;
                ans_q[k]   <= '0;
            end
        end else begin
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        guess_q[cnt_q] <= bus.letter;
                        // The answer is captured with the first letter so later
                        // changes cannot disturb a guess in progress.
                        if (cnt_q == 3'd0) begin
                            for (int k = 0; k < 5; k++) begin
                                ans_q[k] <= bus.answer[5*k +: 5];
                            end
                        end
                        if (cnt_q == 3'd4) begin
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                GREEN: begin
                    green_q  <= green_w;
                    avail_q  <= ~green_w;
                    result_q <= result_grn;
                    win_q    <= 1'b0;
                    idx_q    <= '0;
                end
                YELLOW: begin
                    result_q <= result_upd;
                    avail_q  <= avail_upd;
                    if (idx_q == 3'd4) begin
                        idx_q <= '0;
                        win_q <= (result_upd == 10'b1010101010);
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.letter_ready = (state_q == COLLECT);
    assign bus.result_valid = (state_q == DONE);
    assign bus.result       = result_q;
    assign bus.win          = win_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_wordle_checker.sv
// Directed bench for the Wordle scoring block: latency, duplicate handling,
// handshake hold, ignored letters, answer re-latch and mid-operation reset.
module tb_wordle_checker;

    logic Clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    wordle_checker_if bus ();

    wordle_checker dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // ------------------------------------------------------------------
    // Driver helpers (all return at posedge + 1)
    // ------------------------------------------------------------------
    function automatic logic [24:0] mk_word(input string s);
        logic [24:0] w;
        w = '0;
        for (int k = 0; k < 5; k++) begin
            w[5*k +: 5] = 5'(s[k] - 8'd65);
        end
        return w;
    endfunction

    task automatic send_letters(input string g, input int first, input int last);
        logic [24:0] w;
        w = mk_word(g);
        for (int k = first; k <= last; k++) begin
            bus.letter       = w[5*k +: 5];
            bus.letter_valid = 1'b1;
            @(posedge Clk);
            #1;
        end
        bus.letter_valid = 1'b0;
    endtask

    task automatic wait_result(output int edges);
        edges = 0;
        while (!bus.result_valid && edges < 20) begin
            @(posedge Clk);
            #1;
            edges++;
        end
    endtask

    task automatic do_ack();
        bus.result_ack = 1'b1;
        @(posedge Clk);
        #1;
        bus.result_ack   = 1'b0;
        bus.letter_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset            = 1'b1;
        bus.answer       = '0;
        bus.letter       = '0;
        bus.letter_valid = 1'b0;
        bus.result_ack   = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        reset = 1'b0;
        @(posedge Clk);
        #1;
        n_checks++;
        if (bus.letter_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", bus.letter_ready);
        end
        n_checks++;
        if (bus.result_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", bus.result_valid);
        end
        n_checks++;
        if (bus.result !== 10'd0) begin
            n_fail++; $display("FAIL reset_result: got %b want 0", bus.result);
        end
        n_checks++;
        if (bus.win !== 1'b0) begin
            n_fail++; $display("FAIL reset_win: got %b want 0", bus.win);
        end
        n_checks++;
        if (bus.dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d want 0", bus.dbg_state);
        end
    endtask

    task automatic test_exact_match();
        int edges;
        bus.answer = mk_word("CRANE");
        send_letters("CRANE", 0, 4);
        n_checks++;
        if (bus.letter_ready !== 1'b0) begin
            n_fail++; $display("FAIL exact_ready_low: got %b want 0", bus.letter_ready);
        end
        wait_result(edges);
        n_checks++;
        if (edges !== 6) begin
            n_fail++; $display("FAIL exact_latency: got %0d edges want 6", edges);
        end
        n_checks++;
        if (bus.result !== 10'b1010101010) begin
            n_fail++; $display("FAIL exact_result: got %b want 1010101010", bus.result);
        end
        n_checks++;
        if (bus.win !== 1'b1) begin
            n_fail++; $display("FAIL exact_win: got %b want 1", bus.win);
        end
        do_ack();
        n_checks++;
        if (bus.result_valid !== 1'b0 || bus.letter_ready !== 1'b1) begin
            n_fail++; $display("FAIL exact_ack: got valid=%b ready=%b want valid=0 ready=1",
                               bus.result_valid, bus.letter_ready);
        end
    endtask

    task automatic test_duplicate();
        int edges;
        bus.answer = mk_word("ABBEY");
        send_letters("BABBY", 0, 4);
        wait_result(edges);
        n_checks++;
        if (bus.result !== 10'b1000100101) begin
            n_fail++; $display("FAIL dup_result: got %b want 1000100101", bus.result);
        end
        n_checks++;
        if (bus.win !== 1'b0) begin
            n_fail++; $display("FAIL dup_win: got %b want 0", bus.win);
        end
        do_ack();
    endtask

    task automatic test_hold();
        int edges;
        bus.answer = mk_word("CRANE");
        send_letters("TOUGH", 0, 4);
        wait_result(edges);
        n_checks++;
        if (bus.result !== 10'd0 || bus.win !== 1'b0) begin
            n_fail++; $display("FAIL hold_result: got result=%b win=%b want 0 0", bus.result, bus.win);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk);
            #1;
            n_checks++;
            if (bus.result_valid !== 1'b1 || bus.letter_ready !== 1'b0) begin
                n_fail++; $display("FAIL hold_cycle%0d: got valid=%b ready=%b want valid=1 ready=0",
                                   i, bus.result_valid, bus.letter_ready);
            end
        end
        do_ack();
        n_checks++;
        if (bus.result_valid !== 1'b0 || bus.letter_ready !== 1'b1) begin
            n_fail++; $display("FAIL hold_ack: got valid=%b ready=%b want valid=0 ready=1",
                               bus.result_valid, bus.letter_ready);
        end
    endtask

    task automatic test_ignore_and_relatch();
        int edges;
        bus.answer = mk_word("CRANE");
        send_letters("CRANE", 0, 4);
        // Letter A offered throughout GREEN, YELLOW and DONE.
        bus.letter       = 5'd0;
        bus.letter_valid = 1'b1;
        wait_result(edges);
        repeat (2) @(posedge Clk);
        #1;
        n_checks++;
        if (bus.result !== 10'b1010101010 || bus.win !== 1'b1) begin
            n_fail++; $display("FAIL ignore_result: got result=%b win=%b want 1010101010 1",
                               bus.result, bus.win);
        end
        do_ack();
        // New guess against SLATE; answer changed after the first letter must not matter.
        bus.answer = mk_word("SLATE");
        send_letters("SLATE", 0, 0);
        bus.answer = mk_word("CRANE");
        send_letters("SLATE", 1, 3);
        repeat (3) @(posedge Clk);
        #1;
        n_checks++;
        if (bus.letter_ready !== 1'b1 || bus.result_valid !== 1'b0) begin
            n_fail++; $display("FAIL ignore_four_letters: got ready=%b valid=%b want ready=1 valid=0",
                               bus.letter_ready, bus.result_valid);
        end
        send_letters("SLATE", 4, 4);
        wait_result(edges);
        n_checks++;
        if (edges !== 6) begin
            n_fail++; $display("FAIL relatch_latency: got %0d edges want 6", edges);
        end
        n_checks++;
        if (bus.result !== 10'b1010101010 || bus.win !== 1'b1) begin
            n_fail++; $display("FAIL relatch_result: got result=%b win=%b want 1010101010 1",
                               bus.result, bus.win);
        end
        do_ack();
    endtask

    task automatic test_reset_mid();
        int edges;
        bus.answer = mk_word("CRANE");
        send_letters("TOUGH", 0, 2);
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.result !== 10'd0 || bus.win !== 1'b0 || bus.letter_ready !== 1'b1
            || bus.result_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_collect: got result=%b win=%b ready=%b valid=%b want 0 0 1 0",
                               bus.result, bus.win, bus.letter_ready, bus.result_valid);
        end
        @(posedge Clk);
        #1;
        reset = 1'b0;
        send_letters("CRANE", 0, 4);
        wait_result(edges);
        n_checks++;
        if (edges !== 6 || bus.result !== 10'b1010101010 || bus.win !== 1'b1) begin
            n_fail++; $display("FAIL rst_collect_next: got edges=%0d result=%b win=%b want 6 1010101010 1",
                               edges, bus.result, bus.win);
        end
        do_ack();
        // Reset again two edges into scoring, which is inside YELLOW.
        send_letters("CRANE", 0, 4);
        repeat (2) @(posedge Clk);
        #1;
        n_checks++;
        if (bus.dbg_state !== 2'd2) begin
            n_fail++; $display("FAIL rst_in_yellow_state: got %0d want 2", bus.dbg_state);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.result !== 10'd0 || bus.win !== 1'b0 || bus.letter_ready !== 1'b1
            || bus.result_valid !== 1'b0 || bus.dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL rst_yellow: got result=%b win=%b ready=%b valid=%b state=%0d want 0 0 1 0 0",
                               bus.result, bus.win, bus.letter_ready, bus.result_valid, bus.dbg_state);
        end
        @(posedge Clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_consumed_letters();
        int edges;
        bus.answer = mk_word("EERIE");
        send_letters("EEEEE", 0, 4);
        wait_result(edges);
        n_checks++;
        if (edges !== 6) begin
            n_fail++; $display("FAIL eerie_latency: got %0d edges want 6", edges);
        end
        n_checks++;
        if (bus.result !== 10'b1000001010) begin
            n_fail++; $display("FAIL eerie_result: got %b want 1000001010", bus.result);
        end
        n_checks++;
        if (bus.win !== 1'b0) begin
            n_fail++; $display("FAIL eerie_win: got %b want 0", bus.win);
        end
        do_ack();
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_exact_match();
        test_duplicate();
        test_hold();
        test_ignore_and_relatch();
        test_reset_mid();
        test_consumed_letters();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
